// File: rtl/conc_trace_pkg.sv
// Shared types, defaults and the MISR step for the concolic response capture block.
package conc_trace_pkg;

  localparam int unsigned SIG_W = 16;
  localparam logic [SIG_W-1:0] SIG_POLY_DEF = 16'h1021;
  localparam logic [SIG_W-1:0] SIG_SEED_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // obs_ext is the observed vector already zero-extended to SIG_W bits.
  function automatic logic [SIG_W-1:0] misr_next(
    input logic [SIG_W-1:0] sig,
    input logic [SIG_W-1:0] obs_ext,
    input logic [SIG_W-1:0] poly
  );
    return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? poly : '0) ^ obs_ext;
  endfunction

endpackage

// File: rtl/conc_trace_mem.sv
// Simple dual-port sample store: synchronous write, registered read that holds when re is low.
module conc_trace_mem #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned W     = 38,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/conc_trace_capture.sv
// Captures one DUT output sample per player step with its step index, folds it into a MISR,
// then drains the stored samples oldest-first over a valid/ready port.
module conc_trace_capture
  import conc_trace_pkg::*;
#(
  parameter int unsigned       OBS_W     = 6,
  parameter int unsigned       DEPTH     = 1024,
  parameter int unsigned       MAX_STEPS = 1011,
  parameter logic [SIG_W-1:0]  SIG_POLY  = SIG_POLY_DEF,
  parameter logic [SIG_W-1:0]  SIG_SEED  = SIG_SEED_DEF,
  localparam int unsigned      AW        = $clog2(DEPTH),
  localparam int unsigned      CW        = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cap_en,
  input  logic [OBS_W-1:0] obs_in,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [OBS_W-1:0] rd_data,
  output logic [31:0]      rd_step,
  output logic [CW-1:0]    count,
  output logic [SIG_W-1:0] signature,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned MW = OBS_W + 32;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_busy;
  logic             r_done;
  logic [31:0]      r_step;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_left;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [SIG_W-1:0] r_sig;
  logic             r_ovf;
  logic             r_valid;
  logic             r_pend;
  logic [OBS_W-1:0] r_rd_data;
  logic [31:0]      r_rd_step;

  logic             w_start_ok;
  logic             w_sample;
  logic             w_full;
  logic             w_we;
  logic [31:0]      w_step_inc;
  logic             w_cap_end;
  logic             w_xfer;
  logic             w_load;
  logic             w_re;
  logic [MW-1:0]    w_wdata;
  logic [MW-1:0]    w_rdata;
  logic [SIG_W-1:0] w_obs_ext;

  assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_sample   = (r_state == ST_CAPTURE) && cap_en;
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_we       = w_sample && !w_full;
  assign w_step_inc = r_step + 32'd1;
  assign w_cap_end  = (r_state == ST_CAPTURE) &&
                      (stop || (w_sample && w_step_inc == MAX_STEPS));
  assign w_wdata    = {obs_in, r_step};
  assign w_obs_ext  = SIG_W'(obs_in);

  // The RAM output register only advances when its entry moves into the output
  // register, so it acts as a second pipeline stage and a stall loses nothing.
  assign w_xfer = r_valid && rd_ready;
  assign w_load = r_pend && (!r_valid || w_xfer);
  assign w_re   = (r_state == ST_DRAIN) && (r_left != '0) && (!r_pend || w_load);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE:       if (w_cap_end) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (r_count == '0 || (w_xfer && r_count == CW'(1))) w_state_nxt = ST_DONE;
      end
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_CAPTURE) || (w_state_nxt == ST_DRAIN);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_step    <= '0;
      r_count   <= '0;
      r_left    <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_sig     <= '0;
      r_ovf     <= 1'b0;
      r_valid   <= 1'b0;
      r_pend    <= 1'b0;
      r_rd_data <= '0;
      r_rd_step <= '0;
    end else if (w_start_ok) begin
      r_step   <= '0;
      r_count  <= '0;
      r_left   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_sig    <= SIG_SEED;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      if (w_sample) begin
        r_sig  <= misr_next(r_sig, w_obs_ext, SIG_POLY);
        r_step <= w_step_inc;
        if (!w_full) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end

      if (w_we) begin
        r_count <= r_count + 1'b1;
      end else if (w_xfer) begin
        r_count <= r_count - 1'b1;
      end

      if (w_we) begin
        r_left <= r_left + 1'b1;
      end else if (w_re) begin
        r_left <= r_left - 1'b1;
      end

      if (w_re) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_pend   <= 1'b1;
      end else if (w_load) begin
        r_pend <= 1'b0;
      end

      if (w_load) begin
        r_valid   <= 1'b1;
        r_rd_data <= w_rdata[MW-1 -: OBS_W];
        r_rd_step <= w_rdata[31:0];
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  conc_trace_mem #(
    .DEPTH (DEPTH),
    .W     (MW)
  ) u_mem (
    .clock (clock),
    .we    (w_we),
    .waddr (r_wr_ptr),
    .wdata (w_wdata),
    .re    (w_re),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  assign rd_valid  = r_valid;
  assign rd_data   = r_rd_data;
  assign rd_step   = r_rd_step;
  assign count     = r_count;
  assign signature = r_sig;
  assign overflow  = r_ovf;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_conc_trace_capture.sv
// Scoreboard bench for conc_trace_capture: a full-size and a small (DEPTH 4, MAX_STEPS 8) instance.
module tb_conc_trace_capture;

  logic       clock;
  logic       reset;
  logic       start;
  logic       stop;
  logic       cap_en;
  logic [5:0] obs_in;
  logic       rd_ready;

  logic        b_valid, b_ovf, b_busy, b_done;
  logic [5:0]  b_data;
  logic [31:0] b_step;
  logic [10:0] b_count;
  logic [15:0] b_sig;

  logic        s_valid, s_ovf, s_busy, s_done;
  logic [5:0]  s_data;
  logic [31:0] s_step;
  logic [2:0]  s_count;
  logic [15:0] s_sig;

  conc_trace_capture #(
    .OBS_W(6), .DEPTH(1024), .MAX_STEPS(1011), .SIG_POLY(16'h1021), .SIG_SEED(16'hFFFF)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .cap_en(cap_en),
    .obs_in(obs_in), .rd_valid(b_valid), .rd_ready(rd_ready), .rd_data(b_data),
    .rd_step(b_step), .count(b_count), .signature(b_sig), .overflow(b_ovf),
    .busy(b_busy), .done(b_done)
  );

  conc_trace_capture #(
    .OBS_W(6), .DEPTH(4), .MAX_STEPS(8), .SIG_POLY(16'h1021), .SIG_SEED(16'hFFFF)
  ) dut_s (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .cap_en(cap_en),
    .obs_in(obs_in), .rd_valid(s_valid), .rd_ready(rd_ready), .rd_data(s_data),
    .rd_step(s_step), .count(s_count), .signature(s_sig), .overflow(s_ovf),
    .busy(s_busy), .done(s_done)
  );

  bit          sel;
  logic        m_valid, m_ovf, m_busy, m_done;
  logic [5:0]  m_data;
  logic [31:0] m_step, m_count;
  logic [15:0] m_sig;

  assign m_valid = sel ? s_valid : b_valid;
  assign m_ovf   = sel ? s_ovf   : b_ovf;
  assign m_busy  = sel ? s_busy  : b_busy;
  assign m_done  = sel ? s_done  : b_done;
  assign m_data  = sel ? s_data  : b_data;
  assign m_step  = sel ? s_step  : b_step;
  assign m_count = sel ? 32'(s_count) : 32'(b_count);
  assign m_sig   = sel ? s_sig   : b_sig;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  // Reference model: phase 0 idle/done, 1 capturing, 2 draining.
  int unsigned  phase = 0;
  int unsigned  mdl_depth = 1024;
  int unsigned  mdl_max   = 1011;
  int unsigned  mdl_sig   = 0;
  int unsigned  mdl_step  = 0;
  int unsigned  mdl_stored = 0;
  bit           mdl_ovf   = 0;
  logic [37:0]  exp_q[$];
  int unsigned  xfer_cyc[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_sel(input bit s);
    sel       = s;
    mdl_depth = s ? 4 : 1024;
    mdl_max   = s ? 8 : 1011;
    #1;
  endtask

  task automatic mdl_sample(input logic [5:0] ob);
    int unsigned nxt;
    nxt = (mdl_sig * 2) % 65536;
    if (mdl_sig >= 32768) nxt = nxt ^ 32'h1021;
    nxt = nxt ^ 32'(ob);
    mdl_sig = nxt;
    if (mdl_stored < mdl_depth) begin
      exp_q.push_back({ob, mdl_step});
      mdl_stored++;
    end else begin
      mdl_ovf = 1;
    end
    mdl_step++;
    if (mdl_step == mdl_max) phase = 2;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cycle(input bit st, input bit sp, input bit ce, input logic [5:0] ob);
    start = st; stop = sp; cap_en = ce; obs_in = ob;
    if (phase == 1) begin
      if (ce) mdl_sample(ob);
      if (sp) phase = 2;
    end else if (phase == 0 && st) begin
      mdl_sig = 16'hFFFF; mdl_step = 0; mdl_stored = 0; mdl_ovf = 0; phase = 1;
    end
    tick();
    start = 0; stop = 0; cap_en = 0;
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!m_valid && k < 4) begin
      tick();
      k++;
    end
    chk("first_valid_latency_le2", 64'(k <= 2), 1);
  endtask

  task automatic drain_wait(input bit rnd);
    int k = 0;
    while (!m_done && k < 400) begin
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      k++;
    end
    rd_ready = 0;
    chk("drain_reaches_done", m_done, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("count_after_drain", m_count, 0);
    phase = 0;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_signature"}, m_sig, mdl_sig);
    chk({tag, "_count"}, m_count, mdl_stored);
    chk({tag, "_overflow"}, m_ovf, mdl_ovf);
  endtask

  // Monitor: pops the scoreboard on every accepted transfer and watches stall behaviour.
  bit          prev_stall = 0;
  logic [5:0]  prev_data;
  logic [31:0] prev_step;
  logic [37:0] e;
  always @(negedge clock) begin
    if (!reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("valid_held_during_stall", m_valid, 1);
        if (m_valid) begin
          chk("stall_data_stable", m_data, prev_data);
          chk("stall_step_stable", m_step, prev_step);
        end
      end
      if (m_valid) chk("valid_implies_count", 64'(m_count != 0), 1);
      if (m_valid && rd_ready) begin
        chk("scoreboard_nonempty", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rd_data", m_data, e[37:32]);
          chk("rd_step", m_step, e[31:0]);
        end
        xfer_cyc.push_back(cyc);
      end
      prev_stall = m_valid && !rd_ready;
      prev_data  = m_data;
      prev_step  = m_step;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; start = 0; stop = 0; cap_en = 0; obs_in = '0; rd_ready = 0;
    set_sel(0);

    // Reset held while cap_en toggles.
    for (int i = 0; i < 4; i++) begin
      cap_en = ~cap_en; obs_in = 6'(i + 1);
      tick();
    end
    cap_en = 0;
    for (int s = 0; s < 2; s++) begin
      set_sel(1'(s));
      chk("rst_valid", m_valid, 0);
      chk("rst_busy", m_busy, 0);
      chk("rst_done", m_done, 0);
      chk("rst_overflow", m_ovf, 0);
      chk("rst_count", m_count, 0);
      chk("rst_signature", m_sig, 0);
      chk("rst_rd_data", m_data, 0);
      chk("rst_rd_step", m_step, 0);
    end
    set_sel(0);
    reset = 1;
    tick();

    // Single zero sample.
    cycle(1, 0, 0, 0);
    chk("start_busy", m_busy, 1);
    cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    chk_status("one");
    wait_valid();
    drain_wait(0);
    chk("one_sig_held", m_sig, mdl_sig);
    chk("one_busy_low", m_busy, 0);

    // Five samples, ready held high: back-to-back transfers.
    xfer_cyc.delete();
    cycle(1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) cycle(0, 0, 1, 6'(i));
    rd_ready = 1;
    cycle(0, 1, 0, 0);
    chk_status("five");
    wait_valid();
    drain_wait(0);
    chk("b2b_count", xfer_cyc.size(), 5);
    if (xfer_cyc.size() == 5) chk("b2b_span", xfer_cyc[4] - xfer_cyc[0], 4);

    // Five samples, last coincides with stop, 3-cycle stall on the first entry.
    cycle(1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cycle(0, 0, 1, 6'(i));
    cycle(0, 1, 1, 6'd5);
    chk_status("stall");
    wait_valid();
    for (int i = 0; i < 3; i++) tick();
    drain_wait(0);

    // Randomized rounds with random gaps and random ready.
    for (int r = 0; r < 6; r++) begin
      int n;
      bit last_stop;
      n = int'($urandom_range(1, 40));
      last_stop = 1'($urandom_range(0, 1));
      cycle(1, 0, 0, 0);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0) cycle(0, 0, 0, 6'($urandom));
        cycle(0, last_stop && (i == n - 1), 1, 6'($urandom));
      end
      if (!last_stop) cycle(0, 1, 0, 0);
      chk_status("rand");
      drain_wait(1);
    end

    // Small instance: overflow after 6 samples.
    set_sel(1);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 6'($urandom));
    cycle(0, 1, 0, 0);
    chk_status("ovf");
    chk("ovf_flag", m_ovf, 1);
    chk("ovf_final_step", dut_s.r_step, mdl_step);
    drain_wait(1);
    chk("ovf_held_in_done", m_ovf, 1);

    // Small instance: auto-stop at MAX_STEPS, start in CAPTURE ignored.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 40 && phase == 1; i++) begin
      if (i == 5) cycle(1, 0, 0, 0);
      else if (i % 2 == 0) cycle(0, 0, 1, 6'($urandom));
      else cycle(0, 0, 0, 0);
    end
    chk("auto_busy", m_busy, 1);
    chk_status("auto");
    chk("auto_final_step", dut_s.r_step, mdl_step);
    cycle(0, 0, 1, 6'h3F);
    chk("auto_sig_frozen", m_sig, mdl_sig);
    drain_wait(1);
    cycle(0, 1, 0, 0);
    chk("done_ignores_stop", m_done, 1);
    chk("done_sig_held", m_sig, mdl_sig);

    // Full-size instance: reset asserted mid-drain.
    set_sel(0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 6'($urandom));
    cycle(0, 1, 0, 0);
    wait_valid();
    @(posedge clock);
    #1 reset = 0;
    #1;
    chk("midrst_valid", m_valid, 0);
    chk("midrst_busy", m_busy, 0);
    chk("midrst_done", m_done, 0);
    chk("midrst_count", m_count, 0);
    chk("midrst_signature", m_sig, 0);
    exp_q.delete();
    phase = 0;
    tick();
    reset = 1;
    tick();
    chk("post_rst_idle_busy", m_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
